demux1to2_buf: RTL

DEMUX1TO2_BUF -- requirements
Module: demux1to2_buf

---
 rtl/demux1to2_buf.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/demux1to2_buf.sv
// -----------------------------------------------------------------------------
// demux1to2_buf
//
// Steers a signed data word from a single input stream to one of two
// destinations. Each destination has one registered slot that is either
// EMPTY or FULL. Each destination also has a modulo-256 count of the words
// it has accepted.
//
// Handshake rules (valid/ready) for every channel in this block:
//   - A transfer happens on a rising clk edge when valid and ready are both 1
//     in the cycle before that edge.
//   - valid never depends on ready.
//   - A producer holding valid=1 keeps its data stable until the transfer.
//   - Input side: accept  = in_valid && in_ready.
//   - Output side: drain_k = out_k_valid && out_k_ready.
//   - in_ready is combinational. It looks only at the slot that the current
//     sel addresses, so a stalled slot never blocks traffic to the other one.
//
// Ports
//   clk            in   clock; all state updates happen on the rising edge
//   rst            in   asynchronous, active-high reset
//   in             in   w-bit signed data word to steer
//   sel            in   destination select (0 -> out_0, 1 -> out_1)
//   in_valid       in   in/sel are presented this cycle
//   in_ready       out  block can accept in this cycle
//   out_0, out_1   out  registered data held by each slot
//   out_0_valid    out  slot 0 holds a word
//   out_1_valid    out  slot 1 holds a word
//   out_0_ready    in   downstream 0 consumes the word
//   out_1_ready    in   downstream 1 consumes the word
//   cnt_0, cnt_1   out  words accepted per destination, modulo 256
//   dbg_slot_state out  {slot 1 FULL, slot 0 FULL}, for observation only
// -----------------------------------------------------------------------------
module demux1to2_buf #(
  parameter int w = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [w-1:0] in,
  input  logic                sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [w-1:0] out_0,
  output logic signed [w-1:0] out_1,
  output logic                out_0_valid,
  output logic                out_1_valid,
  input  logic                out_0_ready,
  input  logic                out_1_ready,
  output logic [7:0]          cnt_0,
  output logic [7:0]          cnt_1,
  output logic [1:0]          dbg_slot_state
);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  slot_state_e        state_0_q, state_0_d;
  slot_state_e        state_1_q, state_1_d;
  logic signed [w-1:0] data_0_q, data_0_d;
  logic signed [w-1:0] data_1_q, data_1_d;
  logic [7:0]          cnt_0_q, cnt_0_d;
  logic [7:0]          cnt_1_q, cnt_1_d;

  logic sel_valid;
  logic sel_ready;
  logic accept;
  logic accept_0;
  logic accept_1;
  logic drain_0;
  logic drain_1;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_valid = sel ? out_1_valid : out_0_valid;
    sel_ready = sel ? out_1_ready : out_0_ready;
    // A slot that is draining this cycle can take a new word at the same
    // edge. That lets a stream pass through with no bubble.
    in_ready  = !rst && (!sel_valid || sel_ready);
    accept    = in_valid && in_ready;
    accept_0  = accept && !sel;
    accept_1  = accept && sel;
    // A ready on an EMPTY slot does nothing, because drain needs valid.
    drain_0   = out_0_valid && out_0_ready;
    drain_1   = out_1_valid && out_1_ready;
  end

  // ---------------------------------------------------------------------------
  // Slot 0: next state and data
  // ---------------------------------------------------------------------------
  always_comb begin
    state_0_d = state_0_q;
    data_0_d  = data_0_q;
    cnt_0_d   = cnt_0_q;
    case (state_0_q)
      SLOT_EMPTY: begin
        if (accept_0) state_0_d = SLOT_FULL;
      end
      SLOT_FULL: begin
        // Accept wins over drain: drain+accept keeps the slot FULL with the
        // new word.
        if (accept_0)     state_0_d = SLOT_FULL;
        else if (drain_0) state_0_d = SLOT_EMPTY;
      end
      default: state_0_d = SLOT_EMPTY;
    endcase
    // Data is only overwritten by a new word. After a drain it keeps its
    // last value.
    if (accept_0) begin
      data_0_d = in;
      cnt_0_d  = cnt_0_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot 1: next state and data
  // ---------------------------------------------------------------------------
  always_comb begin
    state_1_d = state_1_q;
    data_1_d  = data_1_q;
    cnt_1_d   = cnt_1_q;
    case (state_1_q)
      SLOT_EMPTY: begin
        if (accept_1) state_1_d = SLOT_FULL;
      end
      SLOT_FULL: begin
        if (accept_1)     state_1_d = SLOT_FULL;
        else if (drain_1) state_1_d = SLOT_EMPTY;
      end
      default: state_1_d = SLOT_EMPTY;
    endcase
    if (accept_1) begin
      data_1_d = in;
      cnt_1_d  = cnt_1_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset clears everything at once without waiting for a
  // clock edge. Any words held in the slots are discarded.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_0_q <= SLOT_EMPTY;
      state_1_q <= SLOT_EMPTY;
      data_0_q  <= '0;
      data_1_q  <= '0;
      cnt_0_q   <= '0;
      cnt_1_q   <= '0;
    end else begin
      state_0_q <= state_0_d;
      state_1_q <= state_1_d;
      data_0_q  <= data_0_d;
      data_1_q  <= data_1_d;
      cnt_0_q   <= cnt_0_d;
      cnt_1_q   <= cnt_1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    out_0          = data_0_q;
    out_1          = data_1_q;
    out_0_valid    = (state_0_q == SLOT_FULL);
    out_1_valid    = (state_1_q == SLOT_FULL);
    cnt_0          = cnt_0_q;
    cnt_1          = cnt_1_q;
    dbg_slot_state = {out_1_valid, out_0_valid};
  end

endmodule
